// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and helpers for the multiplexed seven-segment scan controller.
//   scan_state_t  : scan FSM states (IDLE, BLANK, SHOW)
//   frame_word_t  : one displayable frame (four hex nibbles + four decimal points)
//   NUM_DIGITS    : number of multiplexed digits
//   anode_decode  : digit index -> active-low one-hot anode enables
//   lz_dark       : leading-zero suppression test for one digit of a value
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
    } frame_word_t;

    function automatic logic [3:0] anode_decode(input logic [1:0] digit);
        logic [3:0] onehot;
        onehot = 4'b0001 << digit;
        return ~onehot;
    endfunction

    // A digit is dark when its own nibble and every nibble to its left are
    // zero. Digit 0 always lights so a zero value still shows "0".
    function automatic logic lz_dark(input logic [1:0] digit, input logic [15:0] value);
        logic dark;
        case (digit)
            2'd3:    dark = (value[15:12] == 4'h0);
            2'd2:    dark = (value[15:8]  == 8'h00);
            2'd1:    dark = (value[15:4]  == 12'h000);
            default: dark = 1'b0;
        endcase
        return dark;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// -----------------------------------------------------------------------------
// display_scan_controller_if
// Valid/ready channel carrying a new display value into the scan controller.
//   value_in    : four hex nibbles, [3:0] is the rightmost digit
//   dp_in       : decimal points, one per digit
//   value_valid : source offers value_in/dp_in
//   value_ready : sink's pending buffer is empty
// Modports: master (value source), slave (scan controller).
// -----------------------------------------------------------------------------
interface display_scan_controller_if;
    import display_pkg::*;

    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    value_valid;
    logic                    value_ready;

    modport master (
        output value_in,
        output dp_in,
        output value_valid,
        input  value_ready
    );

    modport slave (
        input  value_in,
        input  dp_in,
        input  value_valid,
        output value_ready
    );

endinterface

// File: rtl/display_dwell_timer.sv
// -----------------------------------------------------------------------------
// display_dwell_timer
// Per-slot cycle counter for the scan controller. Counts 0..DWELL_CYCLES-1 and
// wraps; held at zero while clear is high.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : force the count to zero (scan idle)
//   slot_last    : high in the last cycle of a digit slot
//   blank_done   : high in the last blanking cycle of a slot (never when
//                  BLANK_CYCLES is 0)
// -----------------------------------------------------------------------------
module display_dwell_timer #(
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic slot_last,
    output logic blank_done
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign slot_last  = (count_q == SLOT_LAST);
    assign blank_done = (BLANK_CYCLES > 0) && (count_q == BLANK_LAST);

    always_comb begin
        if (clear || slot_last) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Time-slices one hex-to-segment path across four common anodes, with a
// blanking gap at the start of every digit slot to suppress ghosting. New
// values arrive through a valid/ready channel into a pending buffer and are
// committed to the active buffer only at a frame boundary (or while idle), so
// a frame never shows a mix of two values.
//   clock, reset : system clock, synchronous active-high reset
//   enable       : scan enable; low forces the display dark
//   lz_blank     : leading-zero suppression enable
//   value_if     : value_in/dp_in/value_valid in, value_ready out
//   digit_sel    : index of the current digit slot
//   hex_out      : nibble for the segment decoder
//   dp_out       : decimal point for the current digit
//   anode_n      : active-low one-hot anode enables
//   frame_start  : one-cycle pulse in the first cycle of the digit-0 slot
// All outputs are registered.
// -----------------------------------------------------------------------------
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             lz_blank,
    display_scan_controller_if.slave         value_if,
    output logic [1:0]                       digit_sel,
    output logic [3:0]                       hex_out,
    output logic                             dp_out,
    output logic [3:0]                       anode_n,
    output logic                             frame_start
);

    // With no blanking gap a slot goes straight to SHOW.
    localparam scan_state_t SLOT_ENTRY = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    scan_state_t state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    frame_word_t pending_q, pending_d;
    logic        pend_full_q, pend_full_d;
    frame_word_t active_q, active_d;
    logic        value_ready_q, value_ready_d;
    logic [3:0]  anode_n_q, anode_n_d;
    logic [3:0]  hex_out_q, hex_out_d;
    logic        dp_out_q, dp_out_d;
    logic        frame_start_q, frame_start_d;

    logic slot_last;
    logic blank_done;
    logic timer_clear;
    logic frame_last;
    logic accept;
    logic commit;
    logic dark;

    display_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_dwell_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear),
        .slot_last  (slot_last),
        .blank_done (blank_done)
    );

    // Counter restarts from zero both while idle and on the edge that drops
    // enable, so a re-enable always begins a clean digit-0 slot.
    assign timer_clear = !enable || (state_q == IDLE);

    assign frame_last = (state_q == SHOW) && (digit_q == 2'd3) && slot_last;
    assign accept     = value_if.value_valid && value_ready_q;
    // value_ready is low whenever pend_full is set, so accept and commit are
    // mutually exclusive.
    assign commit     = pend_full_q && ((state_q == IDLE) || frame_last);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        digit_d       = digit_q;
        pending_d     = pending_q;
        pend_full_d   = pend_full_q;
        active_d      = active_q;
        anode_n_d     = 4'b1111;
        hex_out_d     = 4'h0;
        dp_out_d      = 1'b0;
        frame_start_d = 1'b0;
        dark          = 1'b0;

        if (commit) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pending_d.value = value_if.value_in;
            pending_d.dp    = value_if.dp_in;
            pend_full_d     = 1'b1;
        end
        value_ready_d = !pend_full_d;

        if (!enable) begin
            state_d = IDLE;
            digit_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = SLOT_ENTRY;
                    digit_d       = 2'd0;
                    frame_start_d = 1'b1;
                end
                BLANK: begin
                    if (blank_done) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (slot_last) begin
                        state_d       = SLOT_ENTRY;
                        digit_d       = digit_q + 2'd1;
                        frame_start_d = frame_last;
                    end
                end
                default: begin
                    state_d = IDLE;
                    digit_d = 2'd0;
                end
            endcase
        end

        // Outputs are computed from the next-cycle state and buffer so that
        // the registered copies line up with the slot they describe.
        if (state_d != IDLE) begin
            dark      = lz_blank && lz_dark(digit_d, active_d.value);
            hex_out_d = active_d.value[{digit_d, 2'b00} +: 4];
            dp_out_d  = dark ? 1'b0 : active_d.dp[digit_d];
            if ((state_d == SHOW) && !dark) begin
                anode_n_d = anode_decode(digit_d);
            end
        end
    end

    // NOTE: the pending/active buffers are reset as well: reset discards any
    // queued value and the display must come back showing zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            digit_q       <= 2'd0;
            pending_q     <= '0;
            pend_full_q   <= 1'b0;
            active_q      <= '0;
            value_ready_q <= 1'b1;
            anode_n_q     <= 4'b1111;
            hex_out_q     <= 4'h0;
            dp_out_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            pending_q     <= pending_d;
            pend_full_q   <= pend_full_d;
            active_q      <= active_d;
            value_ready_q <= value_ready_d;
            anode_n_q     <= anode_n_d;
            hex_out_q     <= hex_out_d;
            dp_out_q      <= dp_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign value_if.value_ready = value_ready_q;
    assign digit_sel            = digit_q;
    assign hex_out              = hex_out_q;
    assign dp_out               = dp_out_q;
    assign anode_n              = anode_n_q;
    assign frame_start          = frame_start_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
// Drives a DWELL_CYCLES=8 / BLANK_CYCLES=2 controller and a BLANK_CYCLES=0
// controller with identical stimulus. Expected outputs come from a reference
// model that tracks the position inside the frame as a plain cycle offset and
// derives digit, blanking and suppression arithmetically from it.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

    localparam int D = 8;
    localparam int B = 2;
    localparam int F = 4 * D;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        lz_blank;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        value_valid;

    logic [1:0]  digit_sel,   digit_sel0;
    logic [3:0]  hex_out,     hex_out0;
    logic        dp_out,      dp_out0;
    logic [3:0]  anode_n,     anode_n0;
    logic        frame_start, frame_start0;

    display_scan_controller_if vif ();
    display_scan_controller_if vif0 ();

    assign vif.value_in     = value_in;
    assign vif.dp_in        = dp_in;
    assign vif.value_valid  = value_valid;
    assign vif0.value_in    = value_in;
    assign vif0.dp_in       = dp_in;
    assign vif0.value_valid = value_valid;

    display_scan_controller #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .lz_blank    (lz_blank),
        .value_if    (vif.slave),
        .digit_sel   (digit_sel),
        .hex_out     (hex_out),
        .dp_out      (dp_out),
        .anode_n     (anode_n),
        .frame_start (frame_start)
    );

    display_scan_controller #(.DWELL_CYCLES(D), .BLANK_CYCLES(0)) dut0 (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .lz_blank    (lz_blank),
        .value_if    (vif0.slave),
        .digit_sel   (digit_sel0),
        .hex_out     (hex_out0),
        .dp_out      (dp_out0),
        .anode_n     (anode_n0),
        .frame_start (frame_start0)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: whether the scan runs, and the cycle offset
    // inside the current frame.
    bit          m_run;
    int          m_t;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_full;

    logic [3:0]  e_anode, e_anode0, e_hex;
    logic [1:0]  e_digit;
    logic        e_dp, e_fs, e_ready;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (frame offset %0d)", tag, obs, exp, m_t);
        end
    endtask

    // Applies the rules for one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        bit accept;
        bit commit;
        bit dark;
        int d;
        int pos;
        if (reset) begin
            m_run = 0; m_t = 0; m_full = 0;
            m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0;
        end else begin
            accept = value_valid && !m_full;
            commit = m_full && (!m_run || (m_t == F - 1));
            if (commit) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_full = 0;
            end
            if (accept) begin
                m_pend = value_in; m_pend_dp = dp_in; m_full = 1;
            end
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % F;
            end
        end
        e_ready = !m_full;
        if (!m_run) begin
            e_anode = 4'b1111; e_anode0 = 4'b1111; e_digit = 2'd0;
            e_hex = 4'h0; e_dp = 1'b0; e_fs = 1'b0;
        end else begin
            d        = m_t / D;
            pos      = m_t % D;
            dark     = lz_blank && (d > 0) && ((m_act >> (4 * d)) == 16'h0);
            e_digit  = 2'(d);
            e_hex    = 4'(m_act >> (4 * d));
            e_dp     = dark ? 1'b0 : m_act_dp[d];
            e_fs     = (m_t == 0);
            e_anode  = (pos >= B && !dark) ? ~(4'(1 << d)) : 4'b1111;
            e_anode0 = dark ? 4'b1111 : ~(4'(1 << d));
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("anode_n",      16'(anode_n),      16'(e_anode));
        chk("digit_sel",    16'(digit_sel),    16'(e_digit));
        chk("hex_out",      16'(hex_out),      16'(e_hex));
        chk("dp_out",       16'(dp_out),       16'(e_dp));
        chk("frame_start",  16'(frame_start),  16'(e_fs));
        chk("value_ready",  16'(vif.value_ready),  16'(e_ready));
        chk("anode_n_b0",   16'(anode_n0),     16'(e_anode0));
        chk("frame_start_b0", 16'(frame_start0), 16'(e_fs));
    endtask

    // Steps at least once, then until the frame offset reaches target.
    task automatic run_to(input int target);
        int budget;
        budget = 4 * F;
        do begin
            step();
            budget--;
        end while (!(m_run && m_t == target) && budget > 0);
        vectors++;
        assert (m_run && m_t == target) else begin
            miscompares++;
            $error("FAIL run_to: offset %0d not reached, at %0d", target, m_t);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; lz_blank = 1'b0;
        value_in = '0; dp_in = '0; value_valid = 1'b0;
        repeat (3) step();
        chk("rst_ready", 16'(vif.value_ready), 16'h1);
        chk("rst_anode", 16'(anode_n), 16'hF);
        reset = 1'b0;
        step();

        // Load 1234 while idle; it commits on the following idle edge.
        value_in = 16'h1234; dp_in = 4'b0010; value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        step();
        enable = 1'b1;
        step();
        chk("first_fs", 16'(frame_start), 16'h1);
        chk("first_hex", 16'(hex_out), 16'h4);
        repeat (B) step();
        chk("d0_on", 16'(anode_n), 16'hE);
        repeat (2 * F - B - 1) step();

        // Handshake: ABCD accepted mid-frame, 5555 held off until commit.
        run_to(10);
        value_in = 16'hABCD; dp_in = 4'b0101; value_valid = 1'b1;
        step();
        value_in = 16'h5555;
        step();
        chk("ready_low", 16'(vif.value_ready), 16'h0);
        run_to(F - 3);
        value_valid = 1'b0;
        run_to(0);
        chk("commit_ready", 16'(vif.value_ready), 16'h1);
        chk("abcd_d0", 16'(hex_out), 16'hD);
        run_to(3 * D + 4);
        chk("abcd_d3", 16'(hex_out), 16'hA);
        run_to(F - 1);

        // Leading-zero suppression.
        lz_blank = 1'b1;
        value_in = 16'h0070; dp_in = 4'hF; value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        run_to(0);
        run_to(3 * D + 4);
        chk("lz_d3_dark", 16'(anode_n), 16'hF);
        chk("lz_d3_dp", 16'(dp_out), 16'h0);
        run_to(F - 1);
        value_in = 16'h0000; value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        run_to(0);
        run_to(D + 4);
        chk("zero_d1_dark", 16'(anode_n), 16'hF);
        run_to(F - 1);

        // Enable drop in digit-2 SHOW, idle commit, re-enable.
        lz_blank = 1'b0;
        run_to(2 * D + 4);
        enable = 1'b0;
        step();
        chk("drop_anode", 16'(anode_n), 16'hF);
        chk("drop_digit", 16'(digit_sel), 16'h0);
        value_in = 16'h9876; dp_in = 4'b1000; value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        step();
        chk("reen_fs", 16'(frame_start), 16'h1);
        chk("reen_hex", 16'(hex_out), 16'h6);
        run_to(F - 1);

        // Reset during digit-1 SHOW with a value pending.
        value_in = 16'hFEED; value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        run_to(D + 4);
        reset = 1'b1;
        step();
        chk("mid_rst_ready", 16'(vif.value_ready), 16'h1);
        chk("mid_rst_digit", 16'(digit_sel), 16'h0);
        reset = 1'b0;
        step();
        chk("post_rst_hex", 16'(hex_out), 16'h0);
        repeat (F) step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            enable      = ($urandom_range(0, 99) != 0);
            reset       = ($urandom_range(0, 399) == 0);
            value_valid = ($urandom_range(0, 3) == 0);
            dp_in       = 4'($urandom);
            if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
            case ($urandom_range(0, 3))
                0:       value_in = 16'($urandom);
                1:       value_in = 16'($urandom) & 16'h00FF;
                2:       value_in = 16'($urandom) & 16'h000F;
                default: value_in = 16'h0000;
            endcase
            step();
        end
        reset = 1'b0; value_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
